// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern generator: pattern mode encodings.
`timescale 1ns/1ps
package led_pkg;

    typedef enum logic [1:0] {
        MODE_SHIFT  = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_COUNT  = 2'd3
    } mode_t;

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler producing a one-cycle clock enable every 2^DIV_W cycles.
`timescale 1ns/1ps
module led_tick_gen #(
    parameter int DIV_W = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic hold,
    output logic tick
);

    logic [DIV_W-1:0] cnt;

    // Clear wins over hold so a mode change always restarts the step period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (!hold) begin
            cnt <= cnt + DIV_W'(1);
        end
    end

    assign tick = (&cnt) && !hold && !clr;

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: SHIFT, BOUNCE, BLINK and COUNT patterns advanced by a prescaled tick.
`timescale 1ns/1ps
module led_pattern_gen #(
    parameter int N_LEDS     = 8,
    parameter int DIV_W      = 25,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic              pause,
    output logic [N_LEDS-1:0] leds,
    output logic              step
);
    import led_pkg::*;

    localparam int IDX_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_LEDS - 1);

    mode_t             mode_q;
    logic              mode_chg;
    logic              tick;
    logic [IDX_W-1:0]  idx;
    logic              dir_up;
    logic              phase;
    logic [N_LEDS-1:0] count;
    logic [N_LEDS-1:0] lit;

    assign mode_chg = (mode_q != mode_t'(mode));

    led_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (mode_chg),
        .hold  (pause),
        .tick  (tick)
    );

    // idx holds the position to light on the next tick, so the first tick after
    // a clear shows LED 0; BLINK and COUNT display their freshly advanced value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_SHIFT;
            idx    <= '0;
            dir_up <= 1'b1;
            phase  <= 1'b0;
            count  <= '0;
            lit    <= '0;
            step   <= 1'b0;
        end else begin
            mode_q <= mode_t'(mode);
            step   <= 1'b0;
            if (mode_chg) begin
                idx    <= '0;
                dir_up <= 1'b1;
                phase  <= 1'b0;
                count  <= '0;
                lit    <= '0;
            end else if (tick) begin
                step <= 1'b1;
                case (mode_q)
                    MODE_SHIFT: begin
                        lit <= N_LEDS'(1) << idx;
                        idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
                    end
                    MODE_BOUNCE: begin
                        lit <= N_LEDS'(1) << idx;
                        // Direction flips while an endpoint is shown, so it is never repeated.
                        if (dir_up) begin
                            if (idx == IDX_LAST) begin
                                dir_up <= 1'b0;
                                idx    <= idx - IDX_W'(1);
                            end else begin
                                idx <= idx + IDX_W'(1);
                            end
                        end else begin
                            if (idx == '0) begin
                                dir_up <= 1'b1;
                                idx    <= idx + IDX_W'(1);
                            end else begin
                                idx <= idx - IDX_W'(1);
                            end
                        end
                    end
                    MODE_BLINK: begin
                        phase <= ~phase;
                        lit   <= {N_LEDS{~phase}};
                    end
                    MODE_COUNT: begin
                        count <= count + N_LEDS'(1);
                        lit   <= count + N_LEDS'(1);
                    end
                endcase
            end
        end
    end

    assign leds = ACTIVE_LOW ? ~lit : lit;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen against a tick-count based reference model.
`timescale 1ns/1ps
module tb_led_pattern_gen;

    localparam int N  = 4;
    localparam int DW = 2;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   mode  = 2'd0;
    logic         pause = 1'b0;
    logic [N-1:0] leds;
    logic         step;

    int checks   = 0;
    int failures = 0;

    // Reference model: prescaler count, ticks since last clear, registered mode, step.
    int m_pre;
    int m_k;
    int m_mode;
    bit m_step;

    always #5 clk = ~clk;

    led_pattern_gen #(
        .N_LEDS     (N),
        .DIV_W      (DW),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode),
        .pause (pause),
        .leds  (leds),
        .step  (step)
    );

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [N-1:0] exp_leds();
        logic [N-1:0] lit;
        int p;
        lit = '0;
        if (m_k > 0) begin
            case (m_mode)
                0: lit[(m_k - 1) % N] = 1'b1;
                1: begin
                    p = (m_k - 1) % (2 * N - 2);
                    lit[(p < N) ? p : (2 * N - 2 - p)] = 1'b1;
                end
                2: lit = (m_k % 2 == 1) ? '1 : '0;
                default: lit = N'(m_k % (1 << N));
            endcase
        end
        return ~lit;
    endfunction

    task automatic model_reset();
        m_pre  = 0;
        m_k    = 0;
        m_mode = 0;
        m_step = 1'b0;
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else if (int'(mode) != m_mode) begin
            m_mode = int'(mode);
            m_pre  = 0;
            m_k    = 0;
            m_step = 1'b0;
        end else if (pause) begin
            m_step = 1'b0;
        end else if (m_pre == (1 << DW) - 1) begin
            m_pre  = 0;
            m_k    = m_k + 1;
            m_step = 1'b1;
        end else begin
            m_pre  = m_pre + 1;
            m_step = 1'b0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        check("leds", 32'(leds), 32'(exp_leds()));
        check("step", 32'(step), 32'(m_step));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic applyStimulus(input logic [1:0] md, input logic ps, input int n);
        mode  = md;
        pause = ps;
        repeat (n) cycle();
    endtask

    logic [N-1:0] shift_tbl [5];
    logic [N-1:0] bounce_tbl[7];
    int           seen;
    int           guard;

    initial begin
        shift_tbl  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        bounce_tbl = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1011, 4'b1101, 4'b1110};
        model_reset();

        // Reset state while rst_n is held low.
        #2;
        check("reset_leds", 32'(leds), 32'hF);
        check("reset_step", 32'(step), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // SHIFT for five ticks, collecting leds on each step pulse.
        seen = 0;
        mode  = 2'd0;
        pause = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (step && seen < 5) begin
                check("shift_seq", 32'(leds), 32'(shift_tbl[seen]));
                seen++;
            end
        end
        check("shift_ticks", 32'(seen), 32'd5);

        // Pause mid-period: everything frozen, then resumes from held prescaler.
        applyStimulus(2'd0, 1'b0, 2);
        applyStimulus(2'd0, 1'b1, 10);
        applyStimulus(2'd0, 1'b0, 8);

        // BOUNCE for seven ticks (one clearing edge first).
        applyStimulus(2'd1, 1'b0, 1);
        seen = 0;
        for (int i = 0; i < 28; i++) begin
            cycle();
            if (step && seen < 7) begin
                check("bounce_seq", 32'(leds), 32'(bounce_tbl[seen]));
                seen++;
            end
        end
        check("bounce_ticks", 32'(seen), 32'd7);

        // COUNT for seventeen ticks, covering the wrap to zero.
        applyStimulus(2'd3, 1'b0, 1 + 17 * 4);
        check("count_wrap", 32'(leds), 32'hE);

        // Mode change SHIFT -> BLINK landing exactly on a tick edge.
        applyStimulus(2'd0, 1'b0, 1);
        guard = 0;
        while (m_pre != (1 << DW) - 1 && guard < 10) begin
            cycle();
            guard++;
        end
        check("align_guard", 32'(m_pre), 32'((1 << DW) - 1));
        applyStimulus(2'd2, 1'b0, 1);
        check("blink_clear_leds", 32'(leds), 32'hF);
        check("blink_clear_step", 32'(step), 32'h0);
        applyStimulus(2'd2, 1'b0, 4);
        check("blink_on", 32'(leds), 32'h0);

        // Asynchronous reset between edges, right after a COUNT tick.
        applyStimulus(2'd3, 1'b0, 1 + 4 * 3 - 1);
        @(posedge clk);
        model_edge();
        #1;
        check("pre_reset_step", 32'(step), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_leds", 32'(leds), 32'hF);
        check("async_step", 32'(step), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(2'd3, 1'b0, 12);

        // Randomised mode and pause traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            applyStimulus(mode, ($urandom_range(0, 3) == 0), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 SHALL have parameter N_LEDS, default 8, number of LED outputs (legal range 2..32).
REQ-002 SHALL have parameter DIV_W, default 25, prescaler width; step period is 2^DIV_W clk cycles.
REQ-003 SHALL have parameter ACTIVE_LOW, default 1; 1 means a lit LED drives 0.
REQ-004 SHALL have port clk  input  1  system clock; the only clock in the block.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port mode  input  2  pattern select: 0 SHIFT, 1 BOUNCE, 2 BLINK, 3 COUNT.
REQ-007 SHALL have port pause  input  1  while high, freezes the prescaler and the pattern.
REQ-008 SHALL have port leds  output  N_LEDS  registered LED drive, polarity set by ACTIVE_LOW.
REQ-009 SHALL have port step  output  1  one-cycle pulse, high in the cycle after each pattern advance.

Function
REQ-010 SHALL derive the step rate with a clock enable from a DIV_W-bit free-running prescaler; no derived or gated clocks.
REQ-011 SHALL advance the pattern on the rising edge at which the prescaler equals 2^DIV_W-1 and pause=0 (the "tick"); the prescaler wraps to 0 on that same edge.
REQ-012 SHALL update leds on the tick edge itself, from the next pattern state; there is no extra output latency.
REQ-013 SHALL raise step for exactly one cycle following each tick edge.
REQ-014 SHALL in SHIFT light only LED[idx], with idx sequence 0,1,...,N_LEDS-1,0 (wrap-around).
REQ-015 SHALL in BOUNCE light only LED[idx], with idx sequence 0,1,...,N_LEDS-1,N_LEDS-2,...,1,0,1,...; each endpoint is shown once, and direction flips on the tick that reaches an endpoint.
REQ-016 SHALL in BLINK toggle a phase bit on each tick: phase 1 means all LEDs lit, phase 0 means all LEDs dark.
REQ-017 SHALL in COUNT light LEDs per the binary value of an N_LEDS-bit counter that increments each tick and wraps from all-ones to 0.
REQ-018 SHALL register mode every cycle; when the registered mode differs from the input, the next edge SHALL clear the prescaler, idx, direction (up), phase and counter, set leds to all-dark, and raise no step.
REQ-019 SHALL on a mode change coinciding with a tick give the mode change priority; no advance and no step occur on that edge.
REQ-020 SHALL while pause=1 hold the prescaler, pattern state and leds, and keep step low; counting resumes from the held value.
REQ-021 SHALL apply ACTIVE_LOW as the final inversion only; all internal state is active-high.

Reset
REQ-022 SHALL on rst_n=0 immediately clear the prescaler, idx, phase and counter, set direction up, clear step, load the registered mode with 0, and drive leds all-dark (all ones if ACTIVE_LOW=1).
REQ-023 SHALL after rst_n deasserts count from prescaler value 0; the first tick occurs 2^DIV_W cycles later.
REQ-024 SHALL on reset asserted mid-pattern abandon the pattern with no completion; the pattern restarts at idx 0.

Structure
REQ-025 SHALL place the mode encodings (MODE_SHIFT, MODE_BOUNCE, MODE_BLINK, MODE_COUNT) in shared package led_pkg.
REQ-026 SHALL implement the prescaler as sub-module led_tick_gen (ports clk, rst_n, clr, hold; output tick), parametrised by DIV_W.
REQ-027 SHALL keep the pattern state machine and output register in led_pattern_gen.

Verification (DIV_W=2, N_LEDS=4, ACTIVE_LOW=1, so a tick occurs every 4 cycles)
REQ-028 SHALL cover: reset release, then SHIFT held for 5 ticks -> leds 1110, 1101, 1011, 0111, 1110; step pulses spaced 4 cycles apart.
REQ-029 SHALL cover: BOUNCE held for 7 ticks -> idx 0,1,2,3,2,1,0, with no repeated endpoint.
REQ-030 SHALL cover: COUNT held for 17 ticks -> leds equal ~count, and count wraps 1111 to 0000 on tick 16.
REQ-031 SHALL cover: pause=1 for 10 cycles during SHIFT -> leds and step frozen, and the next tick arrives 4 minus the elapsed prescaler cycles after release.
REQ-032 SHALL cover: mode change from SHIFT to BLINK on a tick edge -> no step, leds 1111, then leds 0000 four cycles later.
REQ-033 SHALL cover: rst_n pulled low asynchronously between clock edges -> leds 1111 and step 0 without waiting for a clock edge.
